// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential divider (seq_div32) and its
// restoring-step sub-module (div_step).
//
// Contents:
//   div_state_e  : control FSM states IDLE / CALC / DONE
//   DIV_W        : default operand width
//   CNT_W        : iteration counter width for the default operand width
//   DIV_ZERO_Q   : quotient reported for a zero divisor (all ones)
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W);

    localparam logic [DIV_W-1:0] DIV_ZERO_Q = {DIV_W{1'b1}};

endpackage : div_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring radix-2 division iteration, purely combinational.
// The partial remainder is shifted left by one with the next dividend bit
// entering at the LSB; if the result is not below the divisor magnitude the
// divisor is subtracted and the quotient bit is 1.
//
// Parameters:
//   WIDTH      : operand width
// Ports:
//   rem_in     : in  WIDTH  partial remainder (always < divisor)
//   bit_in     : in  1      next dividend bit, MSB first
//   divisor    : in  WIDTH  divisor magnitude (non-zero)
//   rem_out    : out WIDTH  updated partial remainder
//   q_bit      : out 1      quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder needs one extra bit: with an unsigned divisor
    // close to 2^WIDTH the remainder can approach 2^WIDTH before the shift.
    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] divisor_ext_s;

    // Trial subtraction and restore decision.
    always_comb begin
        trial_s       = {rem_in, bit_in};
        divisor_ext_s = {1'b0, divisor};
        if (trial_s >= divisor_ext_s) begin
            // The difference is below the divisor, so it fits in WIDTH bits.
            rem_out = WIDTH'(trial_s - divisor_ext_s);
            q_bit   = 1'b1;
        end else begin
            rem_out = trial_s[WIDTH-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/seq_div32.sv
// ---------------------------------------------------------------------------
// seq_div32
// Multi-cycle restoring integer divider with valid/ready handshakes on both
// sides. Each operand is independently signed or unsigned (_ns = 1 means
// unsigned). Magnitudes are divided unsigned and signs are re-applied when
// the result is registered: the quotient is negative when exactly one operand
// is negative, the remainder takes the sign of the dividend.
//
// A zero divisor skips the iteration and reports quotient = all ones,
// remainder = original dividend, o_div_by_zero = 1 one cycle after accept.
// Otherwise o_valid rises WIDTH+1 cycles after the accept cycle
// (WIDTH/2+1 with the two-step-per-cycle build).
//
// Build option:
//   SEQ_DIV_RADIX4_EN : when defined, two cascaded restoring steps run per
//                       CALC cycle, halving the iteration count.
//
// Parameters:
//   WIDTH          : operand width (even, >= 4)
// Ports:
//   i_clk          : in  1      clock
//   i_rstn         : in  1      asynchronous active-low reset
//   i_valid        : in  1      request valid
//   o_ready        : out 1      request can be accepted (state IDLE)
//   i_dividend_ns  : in  1      dividend is unsigned
//   i_divisor_ns   : in  1      divisor is unsigned
//   i_dividend     : in  WIDTH  dividend
//   i_divisor      : in  WIDTH  divisor
//   o_valid        : out 1      result valid (state DONE)
//   i_ready        : in  1      consumer accepts the result
//   o_quotient     : out WIDTH  quotient
//   o_remainder    : out WIDTH  remainder
//   o_div_by_zero  : out 1      divisor was zero
// ---------------------------------------------------------------------------
module seq_div32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_dividend_ns,
    input  logic             i_divisor_ns,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CNT_W_L = $clog2(WIDTH);

`ifdef SEQ_DIV_RADIX4_EN
    localparam logic [CNT_W_L-1:0] CNT_LOAD = CNT_W_L'(WIDTH / 2 - 1);
`else
    localparam logic [CNT_W_L-1:0] CNT_LOAD = CNT_W_L'(WIDTH - 1);
`endif

    // Control
    div_state_e         state_r;
    div_state_e         state_nxt_s;
    logic               ready_r;
    logic               valid_r;
    logic               ready_nxt_s;
    logic               valid_nxt_s;
    logic [CNT_W_L-1:0] cnt_r;

    // Datapath: qd_r starts as |dividend|; dividend bits leave at the MSB
    // while quotient bits enter at the LSB, so it ends holding |quotient|.
    logic [WIDTH-1:0]   qd_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   rem_r;
    logic               neg_a_r;
    logic               neg_b_r;

    // Result registers
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               dbz_r;

    // Request decode
    logic               accept_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;

    // Iteration outputs
    logic [WIDTH-1:0]   rem1_s;
    logic               qb1_s;
    logic [WIDTH-1:0]   rem_fin_s;
    logic [WIDTH-1:0]   qd_fin_s;
    logic [WIDTH-1:0]   q_signed_s;
    logic [WIDTH-1:0]   r_signed_s;

    assign o_ready       = ready_r;
    assign o_valid       = valid_r;
    assign o_quotient    = quotient_r;
    assign o_remainder   = remainder_r;
    assign o_div_by_zero = dbz_r;

    // Request decode: sign detection and magnitude conversion of both operands.
    // The magnitude of the most negative value is 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit number.
    always_comb begin
        accept_s   = i_valid & ready_r;
        neg_a_s    = ~i_dividend_ns & i_dividend[WIDTH-1];
        neg_b_s    = ~i_divisor_ns & i_divisor[WIDTH-1];
        div_zero_s = (i_divisor == {WIDTH{1'b0}});
        if (neg_a_s) begin
            mag_a_s = ~i_dividend + WIDTH'(1);
        end else begin
            mag_a_s = i_dividend;
        end
        if (neg_b_s) begin
            mag_b_s = ~i_divisor + WIDTH'(1);
        end else begin
            mag_b_s = i_divisor;
        end
    end

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step0 (
        .rem_in  (rem_r),
        .bit_in  (qd_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (rem1_s),
        .q_bit   (qb1_s)
    );

`ifdef SEQ_DIV_RADIX4_EN
    logic [WIDTH-1:0]   rem2_s;
    logic               qb2_s;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step1 (
        .rem_in  (rem1_s),
        .bit_in  (qd_r[WIDTH-2]),
        .divisor (dvs_r),
        .rem_out (rem2_s),
        .q_bit   (qb2_s)
    );

    // Two quotient bits per cycle.
    always_comb begin
        rem_fin_s = rem2_s;
        qd_fin_s  = {qd_r[WIDTH-3:0], qb1_s, qb2_s};
    end
`else
    // One quotient bit per cycle.
    always_comb begin
        rem_fin_s = rem1_s;
        qd_fin_s  = {qd_r[WIDTH-2:0], qb1_s};
    end
`endif

    // Sign restoration applied on the final iteration. The most negative
    // dividend over -1 yields |q| = 2^(WIDTH-1) with no negation, which is
    // already the wrapped two's-complement result.
    always_comb begin
        if (neg_a_r ^ neg_b_r) begin
            q_signed_s = ~qd_fin_s + WIDTH'(1);
        end else begin
            q_signed_s = qd_fin_s;
        end
        if (neg_a_r) begin
            r_signed_s = ~rem_fin_s + WIDTH'(1);
        end else begin
            r_signed_s = rem_fin_s;
        end
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= ready_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = div_zero_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W_L{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                // No accept while DONE: the new request waits for IDLE.
                if (i_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake output decode from the upcoming state so the flops match it.
    always_comb begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE:    ready_nxt_s = 1'b1;
            DONE:    valid_nxt_s = 1'b1;
            CALC:    ready_nxt_s = 1'b0;
            default: ready_nxt_s = 1'b0;
        endcase
    end

    // Datapath and result registers. Results are only written on entry to
    // DONE, so they stay stable through DONE and the following IDLE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_r       <= {CNT_W_L{1'b0}};
            qd_r        <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            neg_a_r     <= 1'b0;
            neg_b_r     <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        neg_a_r <= neg_a_s;
                        neg_b_r <= neg_b_s;
                        qd_r    <= mag_a_s;
                        dvs_r   <= mag_b_s;
                        rem_r   <= {WIDTH{1'b0}};
                        cnt_r   <= CNT_LOAD;
                        if (div_zero_s) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= i_dividend;
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_fin_s;
                    qd_r  <= qd_fin_s;
                    if (cnt_r == {CNT_W_L{1'b0}}) begin
                        quotient_r  <= q_signed_s;
                        remainder_r <= r_signed_s;
                        dbz_r       <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W_L'(1);
                    end
                end
                DONE: begin
                    dbz_r <= dbz_r;
                end
                default: begin
                    dbz_r <= dbz_r;
                end
            endcase
        end
    end

endmodule : seq_div32

// File: tb/tb_seq_div32.sv
// ---------------------------------------------------------------------------
// tb_seq_div32
// Directed, table-driven bench for seq_div32 (WIDTH = 32) plus hand-written
// sequences for backpressure, back-to-back requests and reset during CALC.
// Latency is counted in clock edges starting with the accept edge.
// ---------------------------------------------------------------------------
module tb_seq_div32;

`ifdef SEQ_DIV_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        i_clk;
    logic        i_rstn;
    logic        i_valid;
    logic        o_ready;
    logic        i_dividend_ns;
    logic        i_divisor_ns;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        dvd_ns;
        logic        dvs_ns;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    seq_div32 #(.WIDTH(32)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_dividend_ns (i_dividend_ns),
        .i_divisor_ns  (i_divisor_ns),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, wait for the result, check it, then release it.
    task automatic do_op(input vec_t v, input string name);
        int lat;
        @(negedge i_clk);
        chk({name, " ready_before"}, {31'd0, o_ready}, 32'd1);
        i_dividend    = v.dvd;
        i_divisor     = v.dvs;
        i_dividend_ns = v.dvd_ns;
        i_divisor_ns  = v.dvs_ns;
        i_valid       = 1'b1;
        i_ready       = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid       = 1'b0;
        // Scramble the operands: they must be ignored after accept.
        i_dividend    = ~v.dvd;
        i_divisor     = 32'h0000_0003;
        i_dividend_ns = ~v.dvd_ns;
        i_divisor_ns  = ~v.dvs_ns;
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({name, " quotient"}, o_quotient, v.exp_q);
        chk({name, " remainder"}, o_remainder, v.exp_r);
        chk({name, " dbz"}, {31'd0, o_div_by_zero}, {31'd0, v.exp_dbz});
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk({name, " ready_after"}, {31'd0, o_ready}, 32'd1);
        chk({name, " valid_after"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        int n;
        vec_t v;
        logic [31:0] held_q;
        logic [31:0] held_r;

        i_rstn        = 1'b0;
        i_valid       = 1'b0;
        i_ready       = 1'b0;
        i_dividend_ns = 1'b1;
        i_divisor_ns  = 1'b1;
        i_dividend    = 32'd0;
        i_divisor     = 32'd0;

        //              dividend       divisor        dns   vns   quotient       remainder      dbz   lat
        vecs[0]  = '{32'd100,      32'd7,         1'b1, 1'b1, 32'd14,        32'd2,         1'b0, LAT};
        vecs[1]  = '{32'hFFFFFFF9, 32'h00000002,  1'b0, 1'b0, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, LAT};
        vecs[2]  = '{32'd5,        32'd0,         1'b1, 1'b1, 32'hFFFFFFFF,  32'd5,         1'b1, 1};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF,  1'b0, 1'b0, 32'h80000000,  32'd0,         1'b0, LAT};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF,  1'b1, 1'b1, 32'd1,         32'd0,         1'b0, LAT};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1,         1'b1, 1'b1, 32'hFFFFFFFF,  32'd0,         1'b0, LAT};
        vecs[6]  = '{32'd7,        32'hFFFFFFFE,  1'b0, 1'b0, 32'hFFFFFFFD,  32'd1,         1'b0, LAT};
        vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE,  1'b0, 1'b0, 32'd3,         32'hFFFFFFFF,  1'b0, LAT};
        vecs[8]  = '{32'hFFFFFFF9, 32'hFFFFFFFE,  1'b1, 1'b0, 32'h80000004,  32'd1,         1'b0, LAT};
        vecs[9]  = '{32'hFFFFFFF9, 32'hFFFFFFFE,  1'b0, 1'b1, 32'd0,         32'hFFFFFFF9,  1'b0, LAT};
        vecs[10] = '{32'hFFFFFFFB, 32'd0,         1'b0, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 1};
        vecs[11] = '{32'd0,        32'd3,         1'b1, 1'b1, 32'd0,         32'd0,         1'b0, LAT};
        vecs[12] = '{32'h80000000, 32'hFFFFFFFF,  1'b1, 1'b1, 32'd0,         32'h80000000,  1'b0, LAT};

        // Reset state
        #12;
        chk("reset ready", {31'd0, o_ready}, 32'd1);
        chk("reset valid", {31'd0, o_valid}, 32'd0);
        chk("reset quotient", o_quotient, 32'd0);
        chk("reset remainder", o_remainder, 32'd0);
        chk("reset dbz", {31'd0, o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Results stay held in IDLE until the next completion
        repeat (3) @(posedge i_clk);
        #1;
        chk("idle hold quotient", o_quotient, 32'd0);
        chk("idle hold remainder", o_remainder, 32'h80000000);

        // Backpressure: 100/7 held in DONE for 10 cycles
        @(negedge i_clk);
        i_dividend = 32'd100; i_divisor = 32'd7;
        i_dividend_ns = 1'b1; i_divisor_ns = 1'b1;
        i_valid = 1'b1; i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("bp reached done", {31'd0, o_valid}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            #1;
            chk("bp quotient", o_quotient, 32'd14);
            chk("bp remainder", o_remainder, 32'd2);
            chk("bp valid", {31'd0, o_valid}, 32'd1);
            chk("bp ready", {31'd0, o_ready}, 32'd0);
        end
        // Release and immediately present 9/3
        @(negedge i_clk);
        i_ready = 1'b1;
        i_dividend = 32'd9; i_divisor = 32'd3;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk("bp release ready", {31'd0, o_ready}, 32'd1);
        chk("bp release valid", {31'd0, o_valid}, 32'd0);
        chk("bp release hold q", o_quotient, 32'd14);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        chk("b2b accepted", {31'd0, o_ready}, 32'd0);
        n = 1;
        while (!o_valid && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("b2b latency", 32'(n), 32'(LAT));
        chk("b2b quotient", o_quotient, 32'd3);
        chk("b2b remainder", o_remainder, 32'd0);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;

        // Reset during CALC, 10 cycles into 100/7
        @(negedge i_clk);
        i_dividend = 32'd100; i_divisor = 32'd7;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("rst valid", {31'd0, o_valid}, 32'd0);
        chk("rst ready", {31'd0, o_ready}, 32'd1);
        chk("rst quotient", o_quotient, 32'd0);
        chk("rst remainder", o_remainder, 32'd0);
        chk("rst dbz", {31'd0, o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) n++;
        end
        chk("rst no result", 32'(n), 32'd0);
        v = '{32'd9, 32'd3, 1'b1, 1'b1, 32'd3, 32'd0, 1'b0, LAT};
        do_op(v, "post-reset 9/3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_div32

// File: doc/seq_div32.md
Name: seq_div32

Overview:
- Multi-cycle integer divider; the inverse companion of the team's registered 32x32 multiplier wrapper.
- Divides a WIDTH-bit dividend by a WIDTH-bit divisor using restoring radix-2 division, one quotient bit per cycle.
- Per-operand signed/unsigned selection uses the same `_ns` flag convention as the multiplier.
- Valid/ready on both sides; sits beside the multiplier in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; must be even and at least 4.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  reset, asynchronous, active-low
- i_valid  input  1  request valid
- o_ready  output  1  block can accept a request
- i_dividend_ns  input  1  1 = dividend unsigned, 0 = two's-complement signed
- i_divisor_ns  input  1  1 = divisor unsigned, 0 = two's-complement signed
- i_dividend  input  WIDTH  dividend
- i_divisor  input  WIDTH  divisor
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_quotient  output  WIDTH  quotient
- o_remainder  output  WIDTH  remainder
- o_div_by_zero  output  1  divisor was zero

Behaviour:
- Clocking/reset: clock i_clk; reset i_rstn, asynchronous, active-low.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, o_div_by_zero=0, counter=0.
- States: IDLE, CALC, DONE. o_ready = (state==IDLE); o_valid = (state==DONE).
- IDLE:
  - On i_valid && o_ready, register both operands and both `_ns` flags.
  - Compute neg_a = ~dividend_ns & dividend[MSB]; neg_b = ~divisor_ns & divisor[MSB].
  - Load magnitudes |a| and |b| as WIDTH-bit unsigned values. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits.
  - If divisor==0, go to DONE. Otherwise clear the partial remainder, set counter=WIDTH−1, go to CALC.
- CALC: each cycle:
  - rem' = {rem, next dividend bit}.
  - If rem' >= |b|, subtract |b| and set the quotient bit to 1; else keep rem' and set the bit to 0.
  - When counter==0, go to DONE; otherwise decrement counter.
- Entry to DONE: register the results.
  - o_quotient = (neg_a ^ neg_b) ? −q : q, truncated to WIDTH.
  - o_remainder = neg_a ? −r : r. The remainder sign follows the dividend.
  - o_div_by_zero = 0.
- Divide by zero: o_quotient = all ones, o_remainder = original dividend, o_div_by_zero = 1. Reaches DONE one cycle after accept.
- Signed overflow (−2^(WIDTH−1) / −1, both signed): o_quotient = 0x80000000, o_remainder = 0. This falls out naturally; no special case.
- Latency: o_valid rises WIDTH+1 cycles after the accept edge (33 for WIDTH=32); 1 cycle for divide by zero.
- DONE:
  - Outputs are held stable while i_ready=0.
  - On i_ready=1, go to IDLE. o_valid drops the next cycle and o_ready rises.
  - No same-cycle accept in DONE. Throughput is one op per WIDTH+2 cycles.
- Outputs are held from DONE through IDLE until the next DONE.
- Inputs are ignored outside the IDLE handshake; changing them during CALC has no effect.
- Asynchronous reset mid-CALC or mid-DONE aborts the operation. All state returns to reset values immediately, and no result is emitted.

Optional Feature:
- Macro: SEQ_DIV_RADIX4_EN.
- When defined: two cascaded restoring steps per CALC cycle. Counter loads WIDTH/2−1. Latency is WIDTH/2+1 (17 for WIDTH=32).
- When undefined: one step per cycle as above.
- Results, divide-by-zero timing, and handshake are identical in both builds.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Default width constant DIV_W=32.
  - Counter width $clog2(DIV_W).
  - Divide-by-zero quotient constant (all ones).
- Sub-module div_step: purely combinational, one restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once, or twice in series under SEQ_DIV_RADIX4_EN.

Test Plan:
- Unsigned 100/7 (both `_ns`=1) -> q=14, r=2, o_div_by_zero=0; o_valid exactly 33 cycles after accept (17 with RADIX4).
- Signed −7/2 (0xFFFFFFF9, 0x00000002, `_ns`=0) -> q=0xFFFFFFFD, r=0xFFFFFFFF.
- Divide by zero, 5/0 unsigned -> q=0xFFFFFFFF, r=5, o_div_by_zero=1, o_valid 1 cycle after accept.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, no flag.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0. Raise i_ready -> o_ready=1 next cycle; a back-to-back request is accepted.
- Reset mid-CALC (cycle 10 of 100/7) -> o_valid=0, o_ready=1, outputs 0. A new 9/3 then yields q=3, r=0.
